btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter IN_WIDTH, default 4: number of independent push-button/switch input channels (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^24.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 arst  input  1  reset, synchronous, active-high.
REQ-005 btn_in  input  IN_WIDTH  raw asynchronous board inputs, bit i = channel i.
REQ-006 btn_state  output  IN_WIDTH  debounced level per channel, registered.
REQ-007 btn_rise  output  IN_WIDTH  one-cycle pulse per channel on accepted 0->1 transition.
REQ-008 btn_fall  output  IN_WIDTH  one-cycle pulse per channel on accepted 1->0 transition.
REQ-009 press_cnt  output  8*IN_WIDTH  per-channel press counter, channel i in bits [8i+7:8i].

Function
REQ-010 Each channel SHALL pass btn_in[i] through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Each channel SHALL own a stability counter, width ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-012 Per edge, if sync2 == btn_state: counter cleared to 0.
REQ-013 Per edge, if sync2 != btn_state and counter < DEBOUNCE_CYCLES-1: counter increments by 1.
REQ-014 Per edge, if sync2 != btn_state and counter == DEBOUNCE_CYCLES-1: btn_state takes sync2, counter cleared, matching rise/fall bit asserted for exactly that next cycle.
REQ-015 Latency: a clean level change first sampled at rising edge k SHALL appear on btn_state, and its pulse, after rising edge k+DEBOUNCE_CYCLES+1.
REQ-016 Any glitch reaching sync2 at the old btn_state level, even for one cycle, SHALL restart the count from 0; no partial credit.
REQ-017 btn_rise and btn_fall SHALL never both be high on one channel in the same cycle; pulses never longer than one cycle.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
REQ-019 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.

Reset
REQ-020 While arst high at a rising edge: sync1, sync2, btn_state, btn_rise, btn_fall, counters, press_cnt all set to 0.
REQ-021 Reset mid-count SHALL discard progress; after release, an input already high SHALL be accepted as a normal 0->1 transition with full latency and a btn_rise pulse.
REQ-022 arst SHALL take priority over every other update in the same cycle.

Configuration
REQ-023 Macro BTN_DEBOUNCE_PRESS_CNT_EN defined: press_cnt[i] increments by 1 on each cycle btn_rise[i] is high, wraps 255 -> 0, cleared only by reset.
REQ-024 Macro BTN_DEBOUNCE_PRESS_CNT_EN undefined: press_cnt port still present, driven constant 0, no counter registers synthesized.

Verification (IN_WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-025 Reset then btn_in[0] 0->1 held -> btn_state[0]=1 and btn_rise[0]=1 for one cycle after edge 6 counted from first sampling edge; other bits stay 0.
REQ-026 btn_in[1] high 3 cycles, low 1 cycle, high 3 cycles -> no btn_state[1] change, no pulses.
REQ-027 btn_in = 4'b1111 from 4'b0000 same cycle -> all four btn_rise bits pulse in the same cycle; release -> all four btn_fall pulse together.
REQ-028 arst asserted 2 cycles into a pending transition with btn_in[2]=1 held -> outputs 0 during reset; btn_rise[2] after the full 6-edge latency post-release.
REQ-029 With BTN_DEBOUNCE_PRESS_CNT_EN, 257 clean presses on channel 3 -> press_cnt[31:24]=1; without macro -> press_cnt=0 throughout.

Source files
------------

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, per-channel stability counter,
// edge pulses. Define BTN_DEBOUNCE_PRESS_CNT_EN to add 8-bit per-channel press counters.
module btn_debounce #(
    parameter int unsigned IN_WIDTH        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [IN_WIDTH-1:0]   btn_in,
    output logic [IN_WIDTH-1:0]   btn_state,
    output logic [IN_WIDTH-1:0]   btn_rise,
    output logic [IN_WIDTH-1:0]   btn_fall,
    output logic [8*IN_WIDTH-1:0] press_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] accept_c;
    logic [CNT_W-1:0]    cnt      [IN_WIDTH];
    logic [CNT_W-1:0]    cnt_next [IN_WIDTH];

    // Any sample matching the current level restarts the count; acceptance also clears it.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != btn_state[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept_c[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_state <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
            for (int i = 0; i < int'(IN_WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_in;
            sync2     <= sync1;
            btn_state <= btn_state ^ accept_c;
            btn_rise  <= accept_c & sync2;
            btn_fall  <= accept_c & ~sync2;
            for (int i = 0; i < int'(IN_WIDTH); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef BTN_DEBOUNCE_PRESS_CNT_EN
    logic [7:0] press_q [IN_WIDTH];

    // Counts accepted presses; wraps naturally at 8 bits.
    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int i = 0; i < int'(IN_WIDTH); i++) begin
                press_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(IN_WIDTH); i++) begin
                if (btn_rise[i]) begin
                    press_q[i] <= press_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        press_cnt = '0;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            press_cnt[8*i +: 8] = press_q[i];
        end
    end
`else
    assign press_cnt = '0;
`endif

endmodule
